// File: rtl/apb_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_pkg
//  Description : Shared types and constants for the APB memory controller:
//                FSM state encoding, wait-state ceiling, error counter width
//                and a saturating increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_mem_pkg;

    // Controller states: SETUP is accepted in IDLE, ACCESS spans WAIT..DONE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Largest supported WAIT_STATES value; sizes the wait counter
    localparam int c_WAIT_MAX  = 15;
    localparam int c_CNT_W     = $clog2(c_WAIT_MAX + 1);

    // Width of the errored-transfer counter
    localparam int c_ERR_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [c_ERR_CNT_W-1:0] sat_inc(input logic [c_ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_ctrl
//  Description : APB slave bridging to a simple synchronous-write /
//                combinational-read word memory. Programmable wait states,
//                out-of-range detection with PSLVERR and a saturating error
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_ctrl
    import apb_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LANES       = 4,
    parameter int WORDS       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDR_W-1:0]        paddr,
    input  logic [8*LANES-1:0]       pwdata,
    input  logic [LANES-1:0]         pstrb,
    output logic [8*LANES-1:0]       prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic                     mem_wr,
    output logic                     mem_rd,
    output logic [LANES-1:0]         mem_be,
    output logic [$clog2(WORDS)-1:0] mem_address,
    output logic [8*LANES-1:0]       mem_data_in,
    input  logic [8*LANES-1:0]       mem_data_out,
    output logic [c_ERR_CNT_W-1:0]   err_cnt
);

    localparam int c_AW = $clog2(WORDS);
    localparam int c_DW = 8 * LANES;

    // Out-of-range parameter values are clamped into the counter's range
    localparam int                  c_WS_INT = (WAIT_STATES > c_WAIT_MAX) ? c_WAIT_MAX :
                                               (WAIT_STATES < 0)          ? 0 : WAIT_STATES;
    localparam logic [c_CNT_W-1:0]  c_WS     = c_CNT_W'(c_WS_INT);

    // First byte address past the memory; one extra bit so the compare never overflows
    localparam logic [ADDR_W:0]     c_SPAN   = (ADDR_W + 1)'(4 * WORDS);

    state_e                 r_state_q,   w_state_d;
    logic [c_CNT_W-1:0]     r_cnt_q,     w_cnt_d;
    logic                   r_write_q,   w_write_d;
    logic                   r_err_q,     w_err_d;
    logic [c_AW-1:0]        r_addr_q,    w_addr_d;
    logic [c_DW-1:0]        r_wdata_q,   w_wdata_d;
    logic [LANES-1:0]       r_strb_q,    w_strb_d;
    logic [c_ERR_CNT_W-1:0] r_err_cnt_q, w_err_cnt_d;
    logic                   r_pready_q,  w_pready_d;
    logic                   r_pslverr_q, w_pslverr_d;
    logic                   r_mem_wr_q,  w_mem_wr_d;
    logic                   r_mem_rd_q,  w_mem_rd_d;
    logic [LANES-1:0]       r_mem_be_q,  w_mem_be_d;

    logic                   w_setup;
    logic                   w_in_oor;
    logic                   w_enter_done;
    logic                   w_ent_write;
    logic                   w_ent_err;
    logic [LANES-1:0]       w_ent_strb;

    assign w_setup  = psel & ~penable;
    assign w_in_oor = ({1'b0, paddr} >= c_SPAN);

    // Next-state, transfer latches and DONE-cycle output decode
    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_write_d    = r_write_q;
        w_err_d      = r_err_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_strb_d     = r_strb_q;
        w_err_cnt_d  = r_err_cnt_q;
        w_enter_done = 1'b0;
        // Attributes of the transfer about to enter DONE: straight from the
        // bus when there are no wait states, otherwise from the latches.
        w_ent_write  = r_write_q;
        w_ent_err    = r_err_q;
        w_ent_strb   = r_strb_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_setup) begin
                    w_write_d   = pwrite;
                    w_err_d     = w_in_oor;
                    w_addr_d    = paddr[c_AW+1:2];
                    w_wdata_d   = pwdata;
                    w_strb_d    = pstrb;
                    w_cnt_d     = c_WS;
                    w_ent_write = pwrite;
                    w_ent_err   = w_in_oor;
                    w_ent_strb  = pstrb;
                    if (c_WS == '0) begin
                        w_state_d    = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A master that drops PSEL mid-transfer abandons it silently
                if (!psel) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                    if (r_cnt_q == c_CNT_W'(1)) begin
                        w_state_d    = S_DONE;
                        w_enter_done = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
                if (r_err_q) begin
                    w_err_cnt_d = sat_inc(r_err_cnt_q);
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Strobes are registered so they are high exactly while in DONE
        w_pready_d  = w_enter_done;
        w_pslverr_d = w_enter_done & w_ent_err;
        w_mem_wr_d  = w_enter_done & w_ent_write & ~w_ent_err;
        w_mem_rd_d  = w_enter_done & ~w_ent_write & ~w_ent_err;
        w_mem_be_d  = w_mem_wr_d ? w_ent_strb : '0;
    end

    // State and output registers; reset clears everything, cancelling any pending write
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= '0;
            r_write_q   <= 1'b0;
            r_err_q     <= 1'b0;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
            r_strb_q    <= '0;
            r_err_cnt_q <= '0;
            r_pready_q  <= 1'b0;
            r_pslverr_q <= 1'b0;
            r_mem_wr_q  <= 1'b0;
            r_mem_rd_q  <= 1'b0;
            r_mem_be_q  <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_write_q   <= w_write_d;
            r_err_q     <= w_err_d;
            r_addr_q    <= w_addr_d;
            r_wdata_q   <= w_wdata_d;
            r_strb_q    <= w_strb_d;
            r_err_cnt_q <= w_err_cnt_d;
            r_pready_q  <= w_pready_d;
            r_pslverr_q <= w_pslverr_d;
            r_mem_wr_q  <= w_mem_wr_d;
            r_mem_rd_q  <= w_mem_rd_d;
            r_mem_be_q  <= w_mem_be_d;
        end
    end

    // Read data passes through from the memory only during a valid read's DONE
    assign prdata      = r_mem_rd_q ? mem_data_out : '0;
    assign pready      = r_pready_q;
    assign pslverr     = r_pslverr_q;
    assign mem_wr      = r_mem_wr_q;
    assign mem_rd      = r_mem_rd_q;
    assign mem_be      = r_mem_be_q;
    assign mem_address = r_addr_q;
    assign mem_data_in = r_wdata_q;
    assign err_cnt     = r_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_mem_ctrl
//  Description : Self-checking bench for apb_mem_ctrl. Two instances
//                (WAIT_STATES 0 and 3) share a transfer-level reference
//                model; a per-cycle compare process checks all outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_mem_ctrl;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        presetn_s [2];
    logic        psel_s    [2];
    logic        penable_s [2];
    logic        pwrite_s  [2];
    logic [31:0] paddr_s   [2];
    logic [31:0] pwdata_s  [2];
    logic [3:0]  pstrb_s   [2];
    logic [31:0] prdata_s  [2];
    logic        pready_s  [2];
    logic        pslverr_s [2];
    logic        mem_wr_s  [2];
    logic        mem_rd_s  [2];
    logic [3:0]  mem_be_s  [2];
    logic [7:0]  mem_addr_s[2];
    logic [31:0] mem_din_s [2];
    logic [31:0] mem_dout_s[2];
    logic [7:0]  err_cnt_s [2];

    apb_mem_ctrl #(.ADDR_W(32), .LANES(4), .WORDS(256), .WAIT_STATES(WS0)) u_dut0 (
        .pclk(pclk), .presetn(presetn_s[0]), .psel(psel_s[0]), .penable(penable_s[0]),
        .pwrite(pwrite_s[0]), .paddr(paddr_s[0]), .pwdata(pwdata_s[0]), .pstrb(pstrb_s[0]),
        .prdata(prdata_s[0]), .pready(pready_s[0]), .pslverr(pslverr_s[0]),
        .mem_wr(mem_wr_s[0]), .mem_rd(mem_rd_s[0]), .mem_be(mem_be_s[0]),
        .mem_address(mem_addr_s[0]), .mem_data_in(mem_din_s[0]),
        .mem_data_out(mem_dout_s[0]), .err_cnt(err_cnt_s[0])
    );

    apb_mem_ctrl #(.ADDR_W(32), .LANES(4), .WORDS(256), .WAIT_STATES(WS1)) u_dut1 (
        .pclk(pclk), .presetn(presetn_s[1]), .psel(psel_s[1]), .penable(penable_s[1]),
        .pwrite(pwrite_s[1]), .paddr(paddr_s[1]), .pwdata(pwdata_s[1]), .pstrb(pstrb_s[1]),
        .prdata(prdata_s[1]), .pready(pready_s[1]), .pslverr(pslverr_s[1]),
        .mem_wr(mem_wr_s[1]), .mem_rd(mem_rd_s[1]), .mem_be(mem_be_s[1]),
        .mem_address(mem_addr_s[1]), .mem_data_in(mem_din_s[1]),
        .mem_data_out(mem_dout_s[1]), .err_cnt(err_cnt_s[1])
    );

    // Attached memories: byte-enabled synchronous write, combinational read
    logic [31:0] mem [2][256];
    logic        mem_clr;
    always @(posedge pclk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_clr) begin
                for (int w = 0; w < 256; w++) mem[i][w] <= '0;
            end else if (mem_wr_s[i]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_s[i][b]) mem[i][mem_addr_s[i]][8*b +: 8] <= mem_din_s[i][8*b +: 8];
            end
        end
    end
    assign mem_dout_s[0] = mem[0][mem_addr_s[0]];
    assign mem_dout_s[1] = mem[1][mem_addr_s[1]];

    // Reference model: memory image and error count per instance
    logic [31:0] ref_mem [2][256];
    int          ref_err [2];

    // Per-cycle expectations, written by the driver, read by the compare process
    logic        exp_pready [2];
    logic        exp_pslverr[2];
    logic        exp_mem_wr [2];
    logic        exp_mem_rd [2];
    logic [3:0]  exp_be     [2];
    logic [31:0] exp_prdata [2];
    logic [7:0]  exp_err    [2];
    logic        exp_avld   [2];
    logic [7:0]  exp_addr   [2];
    logic        exp_wvld   [2];
    logic [31:0] exp_wdata  [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    // Compare process: every output of both instances, every cycle
    always @(negedge pclk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d pready", i),  32'(pready_s[i]),  32'(exp_pready[i]));
                chk($sformatf("dut%0d pslverr", i), 32'(pslverr_s[i]), 32'(exp_pslverr[i]));
                chk($sformatf("dut%0d mem_wr", i),  32'(mem_wr_s[i]),  32'(exp_mem_wr[i]));
                chk($sformatf("dut%0d mem_rd", i),  32'(mem_rd_s[i]),  32'(exp_mem_rd[i]));
                chk($sformatf("dut%0d mem_be", i),  32'(mem_be_s[i]),  32'(exp_be[i]));
                chk($sformatf("dut%0d prdata", i),  prdata_s[i],       exp_prdata[i]);
                chk($sformatf("dut%0d err_cnt", i), 32'(err_cnt_s[i]), 32'(exp_err[i]));
                if (exp_avld[i])
                    chk($sformatf("dut%0d mem_address", i), 32'(mem_addr_s[i]), 32'(exp_addr[i]));
                if (exp_wvld[i])
                    chk($sformatf("dut%0d mem_data_in", i), mem_din_s[i], exp_wdata[i]);
            end
        end
    end

    // One bus cycle: drive instance d (d<0 idles both) and reset expectations
    task automatic cyc(input int d, input logic s, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        @(posedge pclk);
        #1;
        for (int i = 0; i < 2; i++) begin
            psel_s[i]      = (i == d) ? s  : 1'b0;
            penable_s[i]   = (i == d) ? e  : 1'b0;
            pwrite_s[i]    = (i == d) ? w  : 1'b0;
            paddr_s[i]     = (i == d) ? a  : '0;
            pwdata_s[i]    = (i == d) ? wd : '0;
            pstrb_s[i]     = (i == d) ? st : '0;
            exp_pready[i]  = 1'b0;
            exp_pslverr[i] = 1'b0;
            exp_mem_wr[i]  = 1'b0;
            exp_mem_rd[i]  = 1'b0;
            exp_be[i]      = '0;
            exp_prdata[i]  = '0;
            exp_err[i]     = 8'(ref_err[i]);
            exp_avld[i]    = 1'b0;
            exp_addr[i]    = '0;
            exp_wvld[i]    = 1'b0;
            exp_wdata[i]   = '0;
        end
    endtask

    // Full APB transfer; abort_at drops PSEL in that cycle, kill_at pulses reset in it
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int abort_at, input int kill_at,
                        output logic [31:0] rd, output int len, output logic serr);
        int   last;
        int   wi;
        logic oor;
        last = ws_of(d) + 1;
        wi   = int'(a[9:2]);
        oor  = (a >= 32'h400);
        rd   = '0;
        len  = 0;
        serr = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (k == 0)             cyc(d, 1'b1, 1'b0, w, a, wd, st);
            else if (k == abort_at) cyc(d, 1'b0, 1'b0, w, a, wd, st);
            else                    cyc(d, 1'b1, 1'b1, w, a, wd, st);
            if (k == last) begin
                exp_pready[d]  = 1'b1;
                exp_pslverr[d] = oor;
                if (!oor) begin
                    exp_avld[d] = 1'b1;
                    exp_addr[d] = a[9:2];
                    if (w) begin
                        exp_mem_wr[d] = 1'b1;
                        exp_be[d]     = st;
                        exp_wvld[d]   = 1'b1;
                        exp_wdata[d]  = wd;
                    end else begin
                        exp_mem_rd[d] = 1'b1;
                        exp_prdata[d] = ref_mem[d][wi];
                    end
                end
            end
            #4;
            if (pready_s[d] === 1'b1 && len == 0) begin
                len  = k + 1;
                rd   = prdata_s[d];
                serr = pslverr_s[d];
            end
            if (k == kill_at) begin
                #2;
                presetn_s[d] = 1'b0;
                #1;
                chk("rst pready",  32'(pready_s[d]),   32'd0);
                chk("rst pslverr", 32'(pslverr_s[d]),  32'd0);
                chk("rst mem_wr",  32'(mem_wr_s[d]),   32'd0);
                chk("rst mem_rd",  32'(mem_rd_s[d]),   32'd0);
                chk("rst mem_be",  32'(mem_be_s[d]),   32'd0);
                chk("rst prdata",  prdata_s[d],        32'd0);
                chk("rst maddr",   32'(mem_addr_s[d]), 32'd0);
                chk("rst mdin",    mem_din_s[d],       32'd0);
                chk("rst err_cnt", 32'(err_cnt_s[d]),  32'd0);
                ref_err[d] = 0;
                cyc(-1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
                presetn_s[d] = 1'b1;
                return;
            end
            if (k == abort_at) return;
            if (k == last) begin
                if (oor) begin
                    ref_err[d] = (ref_err[d] >= 255) ? 255 : ref_err[d] + 1;
                end else if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (st[b]) ref_mem[d][wi][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
    endtask

    // Idle cycles; some present psel&penable without SETUP, which must be ignored
    task automatic idle(input int n);
        repeat (n) begin
            if ($urandom_range(0, 1) == 0)
                cyc(-1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            else
                cyc($urandom_range(0, 1), 1'b1, 1'b1, 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 63)), $urandom, 4'hF);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          len;
        logic        se;
        int          d;
        int          ab;

        mem_clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            presetn_s[i] = 1'b0;
            psel_s[i] = 1'b0; penable_s[i] = 1'b0; pwrite_s[i] = 1'b0;
            paddr_s[i] = '0;  pwdata_s[i] = '0;   pstrb_s[i] = '0;
            ref_err[i] = 0;
            for (int w = 0; w < 256; w++) ref_mem[i][w] = '0;
            exp_pready[i] = 1'b0; exp_pslverr[i] = 1'b0; exp_mem_wr[i] = 1'b0;
            exp_mem_rd[i] = 1'b0; exp_be[i] = '0; exp_prdata[i] = '0; exp_err[i] = '0;
            exp_avld[i] = 1'b0; exp_addr[i] = '0; exp_wvld[i] = 1'b0; exp_wdata[i] = '0;
        end
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset pready",  32'(pready_s[i]),   32'd0);
            chk("reset prdata",  prdata_s[i],        32'd0);
            chk("reset err_cnt", 32'(err_cnt_s[i]),  32'd0);
            chk("reset maddr",   32'(mem_addr_s[i]), 32'd0);
            chk("reset mem_wr",  32'(mem_wr_s[i]),   32'd0);
            presetn_s[i] = 1'b1;
        end
        mem_clr = 1'b0;
        chk_en  = 1'b1;

        // Zero wait states: write then read back
        xfer(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, -1, -1, rd, len, se);
        chk("ws0 wr len", 32'(len), 32'd2);
        chk("ws0 wr slverr", 32'(se), 32'd0);
        xfer(0, 1'b0, 32'h010, '0, '0, -1, -1, rd, len, se);
        chk("ws0 rd data", rd, 32'hDEADBEEF);
        chk("ws0 rd len", 32'(len), 32'd2);

        // Three wait states, partial strobe at the top word
        xfer(1, 1'b1, 32'h3FC, 32'h11223344, 4'b0101, -1, -1, rd, len, se);
        chk("ws3 wr len", 32'(len), 32'd5);
        xfer(1, 1'b0, 32'h3FC, '0, '0, -1, -1, rd, len, se);
        chk("ws3 rd data", rd, 32'h00220044);
        chk("ws3 rd len", 32'(len), 32'd5);

        // Out-of-range write
        xfer(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, -1, -1, rd, len, se);
        chk("oor slverr", 32'(se), 32'd1);
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("oor err_cnt", 32'(err_cnt_s[0]), 32'd1);
        xfer(0, 1'b0, 32'h000, '0, '0, -1, -1, rd, len, se);
        chk("oor word0 untouched", rd, 32'h0);

        // Abort in the second WAIT cycle
        xfer(1, 1'b1, 32'h020, 32'hA5A5A5A5, 4'hF, 2, -1, rd, len, se);
        chk("abort no pready", 32'(len), 32'd0);
        idle(2);
        xfer(1, 1'b0, 32'h020, '0, '0, -1, -1, rd, len, se);
        chk("abort rd data", rd, 32'h0);
        chk("abort err_cnt", 32'(err_cnt_s[1]), 32'd0);

        // Reset during WAIT, then during DONE; neither write may land
        xfer(1, 1'b1, 32'h040, 32'h5A5A5A5A, 4'hF, -1, 2, rd, len, se);
        xfer(1, 1'b0, 32'h040, '0, '0, -1, -1, rd, len, se);
        chk("kill wait rd", rd, 32'h0);
        xfer(1, 1'b1, 32'h044, 32'hCAFEF00D, 4'hF, -1, -1, rd, len, se);
        xfer(1, 1'b0, 32'h044, '0, '0, -1, -1, rd, len, se);
        chk("post-reset rd", rd, 32'hCAFEF00D);
        xfer(1, 1'b1, 32'h048, 32'h12345678, 4'hF, -1, 4, rd, len, se);
        xfer(1, 1'b0, 32'h048, '0, '0, -1, -1, rd, len, se);
        chk("kill done rd", rd, 32'h0);

        // Randomised traffic, including back-to-back, zero strobes and aborts
        for (int n = 0; n < 200; n++) begin
            d  = $urandom_range(0, 1);
            ab = -1;
            if (ws_of(d) > 0 && $urandom_range(0, 9) == 0) ab = $urandom_range(1, ws_of(d));
            if ($urandom_range(0, 7) == 0)
                xfer(d, 1'($urandom_range(0, 1)), 32'h400 + 32'($urandom_range(0, 100000)),
                     $urandom, 4'($urandom_range(0, 15)), ab, -1, rd, len, se);
            else
                xfer(d, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                     $urandom, 4'($urandom_range(0, 15)), ab, -1, rd, len, se);
            idle($urandom_range(0, 2));
        end

        // Saturation of the error counter
        for (int n = 0; n < 260; n++)
            xfer(0, 1'b0, 32'h400 + 32'(4 * n), '0, '0, -1, -1, rd, len, se);
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("err_cnt saturate", 32'(err_cnt_s[0]), 32'd255);
        chk("model saturate", 32'(ref_err[0]), 32'd255);
        idle(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
